// File: rtl/shift_add_accumulator_pkg.sv
// Shared widths, types and the carry-lookahead helper for the shift-add accumulator.
package shift_add_accumulator_pkg;

  localparam int DATA_W            = 32;
  localparam int ACC_W             = 64;
  localparam int SHIFT_W           = 6;
  localparam int GROUP_WIDTH_DEF   = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ACC_W-1:0]  acc_t;

  // Carry into position lo+n, written as a flat sum of products (no ripple).
  function automatic logic la_carry(input logic [DATA_W-1:0] g,
                                    input logic [DATA_W-1:0] p,
                                    input logic              cin,
                                    input int                lo,
                                    input int                n);
    logic c;
    logic prod;
    prod = cin;
    for (int k = lo; k < lo + n; k++) prod = prod & p[k];
    c = prod;
    for (int k = lo; k < lo + n; k++) begin
      prod = g[k];
      for (int m = k + 1; m < lo + n; m++) prod = prod & p[m];
      c = c | prod;
    end
    return c;
  endfunction

endpackage

// File: rtl/shift_add_accumulator_cla.sv
// 32-bit two-level carry-lookahead adder: per-group lookahead, then lookahead over groups.
module carry_lookahead_adder
  import shift_add_accumulator_pkg::*;
#(
  parameter int GROUP_WIDTH = GROUP_WIDTH_DEF
) (
  input  data_t a_i,
  input  data_t b_i,
  input  logic  cin_i,
  output data_t sum_o,
  output logic  cout_o
);

  localparam int NG = DATA_W / GROUP_WIDTH;

  data_t g;
  data_t p;
  data_t c;
  data_t grpG;
  data_t grpP;
  data_t grpC;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    grpG = '0;
    grpP = '0;
    grpC = '0;
    c    = '0;
    for (int grp = 0; grp < NG; grp++) begin
      grpG[grp] = la_carry(g, p, 1'b0, grp * GROUP_WIDTH, GROUP_WIDTH);
      grpP[grp] = &p[grp*GROUP_WIDTH +: GROUP_WIDTH];
    end
    // Second level: carry into each group straight from group G/P and cin.
    for (int grp = 0; grp < NG; grp++) begin
      grpC[grp] = la_carry(grpG, grpP, cin_i, 0, grp);
    end
    for (int i = 0; i < DATA_W; i++) begin
      c[i] = la_carry(g, p, grpC[i / GROUP_WIDTH], (i / GROUP_WIDTH) * GROUP_WIDTH,
                      i % GROUP_WIDTH);
    end
    sum_o  = p ^ c;
    cout_o = la_carry(grpG, grpP, cin_i, 0, NG);
  end

endmodule

// File: rtl/shift_add_accumulator_expander.sv
// Zero-extending 32-to-64 bit left shifter built from six log-shifter stages.
module shift_expander
  import shift_add_accumulator_pkg::*;
(
  input  data_t              operand_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output acc_t               extended_o
);

  acc_t stage [0:SHIFT_W];

  always_comb begin
    stage[0] = {{(ACC_W-DATA_W){1'b0}}, operand_i};
    for (int k = 0; k < SHIFT_W; k++) begin
      stage[k+1] = shift_i[k] ? (stage[k] << (1 << k)) : stage[k];
    end
    extended_o = stage[SHIFT_W];
  end

endmodule

// File: rtl/shift_add_accumulator.sv
// Registered 64-bit shift-and-accumulate core of the iterative shift-add multiplier.
module shift_add_accumulator
  import shift_add_accumulator_pkg::*;
#(
  parameter int GROUP_WIDTH = GROUP_WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  data_t              operand,
  input  logic [SHIFT_W-1:0] shift,
  output data_t              output_lower,
  output data_t              output_higher,
  output logic               carry_out
);

  acc_t  acc_q, acc_d;
  logic  carry_q, carry_d;
  acc_t  extended;
  acc_t  addend;
  data_t sumLo, sumHi;
  logic  carryLo, carryHi;

  shift_expander u_expander (
    .operand_i  (operand),
    .shift_i    (shift),
    .extended_o (extended)
  );

  assign addend = clear ? '0 : acc_q;

  carry_lookahead_adder #(.GROUP_WIDTH(GROUP_WIDTH)) u_cla_lo (
    .a_i    (addend[DATA_W-1:0]),
    .b_i    (extended[DATA_W-1:0]),
    .cin_i  (1'b0),
    .sum_o  (sumLo),
    .cout_o (carryLo)
  );

  carry_lookahead_adder #(.GROUP_WIDTH(GROUP_WIDTH)) u_cla_hi (
    .a_i    (addend[ACC_W-1:DATA_W]),
    .b_i    (extended[ACC_W-1:DATA_W]),
    .cin_i  (carryLo),
    .sum_o  (sumHi),
    .cout_o (carryHi)
  );

  // Enable wins over a bare clear; with clear+enable the addend is zero, so no carry.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (enable) begin
      acc_d   = {sumHi, sumLo};
      carry_d = carryHi;
    end else if (clear) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign output_lower  = acc_q[DATA_W-1:0];
  assign output_higher = acc_q[ACC_W-1:DATA_W];
  assign carry_out     = carry_q;

endmodule

// File: tb/tb_shift_add_accumulator.sv
// Directed-vector and reference-model bench for shift_add_accumulator.
module tb_shift_add_accumulator;

  typedef struct {
    string       name;
    logic        clr;
    logic        en;
    logic [31:0] op;
    logic [5:0]  sh;
    logic [31:0] expLo;
    logic [31:0] expHi;
    logic        expCarry;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        enable;
  logic [31:0] operand;
  logic [5:0]  shift;
  logic [31:0] outputLower;
  logic [31:0] outputHigher;
  logic        carryOut;

  int checkCount;
  int passCount;

  shift_add_accumulator dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .enable        (enable),
    .operand       (operand),
    .shift         (shift),
    .output_lower  (outputLower),
    .output_higher (outputHigher),
    .carry_out     (carryOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle's inputs, let the edge happen, and settle just after it.
  task automatic applyStimulus(input logic rst, input logic clr, input logic en,
                               input logic [31:0] op, input logic [5:0] sh);
    reset   = rst;
    clear   = clr;
    enable  = en;
    operand = op;
    shift   = sh;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expLo,
                             input logic [31:0] expHi, input logic expCarry);
    checkCount++;
    if (outputLower === expLo && outputHigher === expHi && carryOut === expCarry) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got hi=%08h lo=%08h c=%0b, expected hi=%08h lo=%08h c=%0b",
               name, outputHigher, outputLower, carryOut, expHi, expLo, expCarry);
    end
  endtask

  vec_t        vecs [13];
  logic [63:0] modelAcc;
  logic        modelCarry;
  logic [64:0] wide;
  logic [63:0] ext;
  logic [31:0] mulA;
  logic [31:0] mulB;

  initial begin
    checkCount = 0;
    passCount  = 0;

    vecs[0]  = '{"crossLoad",   1'b1, 1'b1, 32'hFFFF_FFFF, 6'd0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{"crossCarry",  1'b0, 1'b1, 32'h0000_0001, 6'd0,  32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[2]  = '{"shift63",     1'b1, 1'b1, 32'h0000_0003, 6'd63, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[3]  = '{"shift32",     1'b1, 1'b1, 32'h0000_0001, 6'd32, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[4]  = '{"ovfLoad",     1'b1, 1'b1, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{"ovfFill",     1'b0, 1'b1, 32'hFFFF_FFFF, 6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"ovfWrap",     1'b0, 1'b1, 32'h0000_0001, 6'd0,  32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{"ovfHold",     1'b0, 1'b0, 32'hDEAD_BEEF, 6'd7,  32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{"clearOnly",   1'b1, 1'b0, 32'hDEAD_BEEF, 6'd9,  32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{"loadShift4",  1'b1, 1'b1, 32'h1234_5678, 6'd4,  32'h2345_6780, 32'h0000_0001, 1'b0};
    vecs[10] = '{"addShift31",  1'b0, 1'b1, 32'h8000_0000, 6'd31, 32'h2345_6780, 32'h4000_0001, 1'b0};
    vecs[11] = '{"idleHold",    1'b0, 1'b0, 32'h5555_5555, 6'd1,  32'h2345_6780, 32'h4000_0001, 1'b0};
    vecs[12] = '{"addShift33",  1'b0, 1'b1, 32'hFFFF_FFFF, 6'd33, 32'h2345_6780, 32'h3FFF_FFFF, 1'b1};

    // Reset held two cycles against random inputs with enable high.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'b1, $urandom, 6'($urandom));
      checkOutput("reset", 32'h0, 32'h0, 1'b0);
    end

    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].clr, vecs[i].en, vecs[i].op, vecs[i].sh);
      checkOutput(vecs[i].name, vecs[i].expLo, vecs[i].expHi, vecs[i].expCarry);
    end

    // Reset together with clear and enable beats both.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 6'd0);
    checkOutput("resetPriority", 32'h0, 32'h0, 1'b0);

    // Reset mid-accumulation with only enable high.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 6'd40);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1234, 6'd3);
    checkOutput("resetMidSeq", 32'h0, 32'h0, 1'b0);

    // Multiply sequences: cycle i adds the multiplicand at shift i when bit i is set.
    for (int t = 0; t < 2; t++) begin
      mulA = (t == 0) ? 32'hFFFF_FFFF : 32'h1234_5678;
      mulB = (t == 0) ? 32'hFFFF_FFFF : 32'h9ABC_DEF0;
      for (int i = 0; i < 32; i++) begin
        applyStimulus(1'b0, (i == 0), 1'b1, mulB[i] ? mulA : 32'h0, 6'(i));
      end
      if (t == 0) checkOutput("mulAllOnes", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
      else        checkOutput("mulMixed",   32'h242D_2080, 32'h0B00_EA4E, 1'b0);
    end

    // Random traffic against a 64-bit reference model.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 6'd0);
    modelAcc   = '0;
    modelCarry = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic        rClr;
      logic        rEn;
      logic [31:0] rOp;
      logic [5:0]  rSh;
      rClr = ($urandom_range(0, 3) == 0);
      rEn  = ($urandom_range(0, 3) != 0);
      rOp  = $urandom;
      rSh  = 6'($urandom);
      ext  = {32'h0, rOp} << rSh;
      if (rEn) begin
        wide       = {1'b0, (rClr ? 64'h0 : modelAcc)} + {1'b0, ext};
        modelAcc   = wide[63:0];
        modelCarry = wide[64];
      end else if (rClr) begin
        modelAcc   = '0;
        modelCarry = 1'b0;
      end
      applyStimulus(1'b0, rClr, rEn, rOp, rSh);
      checkOutput("random", modelAcc[31:0], modelAcc[63:32], modelCarry);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
